// File: rtl/opcmp_pkg.sv
// Shared types, default sizes and helpers for the operator-compare sweep controller.
package opcmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEF      = 8;
  localparam int RW_DEF     = 21;
  localparam int SETTLE_DEF = 1;
  localparam int CW_DEF     = 16;

  // Increment v, but stick at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/opcmp_vec_gen.sv
// Operand pair counter: b is the inner (fast) digit, a the outer one.
module opcmp_vec_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         last
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;

  // Next operand pair: clear wins over step; a advances when b wraps.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clr) begin
      a_d = '0;
      b_d = '0;
    end else if (step) begin
      b_d = b_q + W'(1);
      if (&b_q) a_d = a_q + W'(1);
    end
  end

  // Operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign last = (&a_q) & (&b_q);

endmodule

// File: rtl/opcmp_sweep_ctrl.sv
// Exhaustive (a, b) sweep that compares two operator result bundles,
// records the first mismatch and reports pass/fail via start/done.
module opcmp_sweep_ctrl
  import opcmp_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int RW           = RW_DEF,
  parameter int SETTLE       = SETTLE_DEF,
  parameter bit STOP_ON_FAIL = 1'b1,
  parameter int CW           = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [W-1:0]    a_o,
  output logic [W-1:0]    b_o,
  input  logic [RW-1:0]   res1_i,
  input  logic [RW-1:0]   res2_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            aborted,
  output logic [W-1:0]    fail_a,
  output logic [W-1:0]    fail_b,
  output logic [RW-1:0]   fail_r1,
  output logic [RW-1:0]   fail_r2,
  output logic [CW-1:0]   err_cnt,
  output logic [2*W:0]    vec_cnt
);

  localparam int         VW          = 2 * W + 1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [VW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [W-1:0]    fail_a_q, fail_a_d;
  logic [W-1:0]    fail_b_q, fail_b_d;
  logic [RW-1:0]   fail_r1_q, fail_r1_d;
  logic [RW-1:0]   fail_r2_q, fail_r2_d;
  logic            pass_q, pass_d;
  logic            aborted_q, aborted_d;

  logic            gen_clr, gen_step, gen_last;
  logic [W-1:0]    gen_a, gen_b;
  logic            mismatch;

  opcmp_vec_gen #(.W(W)) u_vec_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gen_clr),
    .step  (gen_step),
    .a     (gen_a),
    .b     (gen_b),
    .last  (gen_last)
  );

  assign mismatch = |(res1_i ^ res2_i);

  // Sequencer: next state, counter updates, first-mismatch capture, operand stepping.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    err_cnt_d = err_cnt_q;
    vec_cnt_d = vec_cnt_q;
    fail_a_d  = fail_a_q;
    fail_b_d  = fail_b_q;
    fail_r1_d = fail_r1_q;
    fail_r2_d = fail_r2_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    gen_clr   = 1'b0;
    gen_step  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          gen_clr   = 1'b1;
          err_cnt_d = '0;
          vec_cnt_d = '0;
          fail_a_d  = '0;
          fail_b_d  = '0;
          fail_r1_d = '0;
          fail_r2_d = '0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
          settle_d  = SETTLE_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        // The compare and its bookkeeping happen even when aborting this cycle.
        vec_cnt_d = vec_cnt_q + VW'(1);
        if (mismatch) begin
          err_cnt_d = CW'(sat_inc(32'(err_cnt_q), CW));
          if (err_cnt_q == '0) begin
            fail_a_d  = gen_a;
            fail_b_d  = gen_b;
            fail_r1_d = res1_i;
            fail_r2_d = res2_i;
          end
        end
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else if (mismatch && STOP_ON_FAIL) begin
          state_d = DONE;
          pass_d  = 1'b0;
        end else if (gen_last) begin
          state_d = DONE;
          pass_d  = (err_cnt_d == '0);
        end else begin
          gen_step = 1'b1;
          settle_d = SETTLE_LOAD;
          state_d  = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      err_cnt_q <= '0;
      vec_cnt_q <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_r1_q <= '0;
      fail_r2_q <= '0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      err_cnt_q <= err_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      fail_a_q  <= fail_a_d;
      fail_b_q  <= fail_b_d;
      fail_r1_q <= fail_r1_d;
      fail_r2_q <= fail_r2_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
    end
  end

  assign a_o     = gen_a;
  assign b_o     = gen_b;
  assign busy    = (state_q == WAIT) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign aborted = aborted_q;
  assign fail_a  = fail_a_q;
  assign fail_b  = fail_b_q;
  assign fail_r1 = fail_r1_q;
  assign fail_r2 = fail_r2_q;
  assign err_cnt = err_cnt_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_opcmp_sweep_ctrl.sv
// Bench for opcmp_sweep_ctrl: two instances (stop-on-fail with SETTLE=2 and a
// 16-bit counter; run-through with SETTLE=1 and a 4-bit saturating counter),
// reduced to W=5 so that full sweeps stay short.
module tb_opcmp_sweep_ctrl;

  localparam int W   = 5;
  localparam int RW  = 21;
  localparam int S0  = 2;
  localparam int S1  = 1;
  localparam int NV  = 1 << (2 * W);
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst_n, start, abort;

  logic [W-1:0]  a_o [2];
  logic [W-1:0]  b_o [2];
  logic [W-1:0]  fail_a [2];
  logic [W-1:0]  fail_b [2];
  logic [RW-1:0] res1 [2];
  logic [RW-1:0] res2 [2];
  logic [RW-1:0] fail_r1 [2];
  logic [RW-1:0] fail_r2 [2];
  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic          aborted [2];
  logic [2*W:0]  vec_cnt [2];
  logic [15:0]   err_cnt0;
  logic [3:0]    err_cnt1;

  int            mode = 0;
  int            fa = 0, fb = 0, seed = 0;
  logic [RW-1:0] mask = 21'h000008;

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc [2];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arbitrary but deterministic "operator" result.
  function automatic logic [RW-1:0] ref_res(input int a, input int b);
    logic [4:0] flags;
    flags = {a[0], b[0], a == b, a < b, ^a[W-1:0]};
    return {8'(a * b), 8'(a + b), flags};
  endfunction

  // Which (a, b) pairs make implementation 2 disagree.
  function automatic bit pred(input int md, input int a, input int b,
                              input int xa, input int xb, input int sd);
    case (md)
      1:       return (a == xa) && (b == xb);
      2:       return b == ((1 << W) - 1);
      3:       return ((a * 5 + b * 3 + sd) % 37) == 0;
      default: return 1'b0;
    endcase
  endfunction

  assign res1[0] = ref_res(int'(a_o[0]), int'(b_o[0]));
  assign res1[1] = ref_res(int'(a_o[1]), int'(b_o[1]));
  assign res2[0] = res1[0] ^ (pred(mode, int'(a_o[0]), int'(b_o[0]), fa, fb, seed) ? mask : '0);
  assign res2[1] = res1[1] ^ (pred(mode, int'(a_o[1]), int'(b_o[1]), fa, fb, seed) ? mask : '0);

  opcmp_sweep_ctrl #(.W(W), .RW(RW), .SETTLE(S0), .STOP_ON_FAIL(1'b1), .CW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o[0]), .b_o(b_o[0]), .res1_i(res1[0]), .res2_i(res2[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .aborted(aborted[0]),
    .fail_a(fail_a[0]), .fail_b(fail_b[0]), .fail_r1(fail_r1[0]), .fail_r2(fail_r2[0]),
    .err_cnt(err_cnt0), .vec_cnt(vec_cnt[0])
  );

  opcmp_sweep_ctrl #(.W(W), .RW(RW), .SETTLE(S1), .STOP_ON_FAIL(1'b0), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o[1]), .b_o(b_o[1]), .res1_i(res1[1]), .res2_i(res2[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .aborted(aborted[1]),
    .fail_a(fail_a[1]), .fail_b(fail_b[1]), .fail_r1(fail_r1[1]), .fail_r2(fail_r2[1]),
    .err_cnt(err_cnt1), .vec_cnt(vec_cnt[1])
  );

  function automatic int settle_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  function automatic int errc(input int k);
    return (k == 0) ? int'(err_cnt0) : int'(err_cnt1);
  endfunction

  // Sweep outcome from the rules: a outer, b inner; instance 0 stops at the
  // first mismatch, instance 1 runs through with a 4-bit saturating count.
  task automatic model(input int k, input int md, output int n_vec, output int errs,
                       output bit has_fail, output int f_a, output int f_b,
                       output int end_a, output int end_b);
    int  n    = 1 << W;
    int  cmax = (k == 0) ? 65535 : 15;
    bit  fin  = 1'b0;
    n_vec = 0; errs = 0; has_fail = 1'b0; f_a = 0; f_b = 0; end_a = 0; end_b = 0;
    for (int a = 0; a < n && !fin; a++) begin
      for (int b = 0; b < n && !fin; b++) begin
        n_vec++;
        end_a = a;
        end_b = b;
        if (pred(md, a, b, fa, fb, seed)) begin
          if (errs < cmax) errs++;
          if (!has_fail) begin has_fail = 1'b1; f_a = a; f_b = b; end
          if (k == 0) fin = 1'b1;
        end
      end
    end
  endtask

  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  // Wait for both instances' done; optionally pulse start while they are busy.
  task automatic wait_both(input int busy_start_at);
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      start = (busy_start_at >= 0) && (cyc - start_cyc >= busy_start_at) &&
              (cyc - start_cyc < busy_start_at + 3);
      for (int k = 0; k < 2; k++)
        if (done[k] && done_cyc[k] < 0) done_cyc[k] = cyc - start_cyc;
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_o[k], b_o[k], busy[k], done[k], pass[k], aborted[k], fail_a[k], fail_b[k],
           fail_r1[k], fail_r2[k], vec_cnt[k]} !== '0 || errc(k) != 0) begin
        errors++;
        $display("FAIL reset dut%0d: a=%0d b=%0d busy=%0b done=%0b pass=%0b ab=%0b vec=%0d err=%0d, all required 0",
                 k, a_o[k], b_o[k], busy[k], done[k], pass[k], aborted[k], vec_cnt[k], errc(k));
      end
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_sweep(input int md, input string name, input int busy_start_at);
    int n_vec, errs, f_a, f_b, end_a, end_b;
    bit has_fail;
    logic [RW-1:0] er1, er2;
    mode = md;
    launch();
    wait_both(busy_start_at);
    for (int k = 0; k < 2; k++) begin
      model(k, md, n_vec, errs, has_fail, f_a, f_b, end_a, end_b);
      er1 = has_fail ? ref_res(f_a, f_b) : '0;
      er2 = has_fail ? (ref_res(f_a, f_b) ^ mask) : '0;
      $display("sweep %s dut%0d: vec=%0d err=%0d pass=%0b cycles=%0d", name, k,
               vec_cnt[k], errc(k), pass[k], done_cyc[k]);
      checks++;
      if (done_cyc[k] != n_vec * (settle_of(k) + 1)) begin
        errors++;
        $display("FAIL %s dut%0d done_cycles: got %0d required %0d", name, k, done_cyc[k], n_vec * (settle_of(k) + 1));
      end
      checks++;
      if (pass[k] !== !has_fail || aborted[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s dut%0d flags: pass=%0b aborted=%0b busy=%0b done=%0b required %0b/0/0/1",
                 name, k, pass[k], aborted[k], busy[k], done[k], !has_fail);
      end
      checks++;
      if (errc(k) != errs) begin
        errors++;
        $display("FAIL %s dut%0d err_cnt: got %0d required %0d", name, k, errc(k), errs);
      end
      checks++;
      if (int'(vec_cnt[k]) != n_vec) begin
        errors++;
        $display("FAIL %s dut%0d vec_cnt: got %0d required %0d", name, k, vec_cnt[k], n_vec);
      end
      checks++;
      if (int'(a_o[k]) != end_a || int'(b_o[k]) != end_b) begin
        errors++;
        $display("FAIL %s dut%0d operands: got %0d,%0d required %0d,%0d", name, k, a_o[k], b_o[k], end_a, end_b);
      end
      checks++;
      if (int'(fail_a[k]) != f_a || int'(fail_b[k]) != f_b || fail_r1[k] !== er1 || fail_r2[k] !== er2) begin
        errors++;
        $display("FAIL %s dut%0d capture: got a=%0d b=%0d r1=%h r2=%h required a=%0d b=%0d r1=%h r2=%h",
                 name, k, fail_a[k], fail_b[k], fail_r1[k], fail_r2[k], f_a, f_b, er1, er2);
      end
    end
  endtask

  task automatic test_restart();
    mode = 0;
    launch();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({fail_a[k], fail_b[k], fail_r1[k], fail_r2[k], vec_cnt[k], pass[k], aborted[k],
           a_o[k], b_o[k], done[k]} !== '0 || errc(k) != 0 || busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL restart_clear dut%0d: fa=%0d fb=%0d vec=%0d err=%0d pass=%0b busy=%0b required cleared and busy",
                 k, fail_a[k], fail_b[k], vec_cnt[k], errc(k), pass[k], busy[k]);
      end
    end
    wait_both(-1);
    for (int k = 0; k < 2; k++) begin
      $display("restart dut%0d: pass=%0b cycles=%0d", k, pass[k], done_cyc[k]);
      checks++;
      if (pass[k] !== 1'b1 || done_cyc[k] != NV * (settle_of(k) + 1)) begin
        errors++;
        $display("FAIL restart_sweep dut%0d: pass=%0b cycles=%0d required 1 and %0d",
                 k, pass[k], done_cyc[k], NV * (settle_of(k) + 1));
      end
    end
  endtask

  // abort is sampled at the edge T cycles after the start edge.
  task automatic test_abort(input int t);
    int v, idx;
    mode = 0;
    launch();
    while (cyc - start_cyc < t - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v   = t / (settle_of(k) + 1);
      idx = (t % (settle_of(k) + 1) == 0) ? v - 1 : v;
      $display("abort t=%0d dut%0d: vec=%0d a=%0d b=%0d", t, k, vec_cnt[k], a_o[k], b_o[k]);
      checks++;
      if (done[k] !== 1'b1 || aborted[k] !== 1'b1 || pass[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL abort dut%0d flags: done=%0b aborted=%0b pass=%0b busy=%0b required 1/1/0/0",
                 k, done[k], aborted[k], pass[k], busy[k]);
      end
      checks++;
      if (int'(vec_cnt[k]) != v || int'(a_o[k]) != (idx >> W) || int'(b_o[k]) != (idx % (1 << W))) begin
        errors++;
        $display("FAIL abort dut%0d position: vec=%0d a=%0d b=%0d required vec=%0d a=%0d b=%0d",
                 k, vec_cnt[k], a_o[k], b_o[k], v, idx >> W, idx % (1 << W));
      end
    end
  endtask

  task automatic test_reset_mid();
    int wait_c = int'($urandom_range(10, 500));
    mode = 0;
    launch();
    repeat (wait_c) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_o[k], b_o[k], busy[k], done[k], pass[k], vec_cnt[k]} !== '0 || errc(k) != 0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: a=%0d b=%0d busy=%0b done=%0b vec=%0d required all 0",
                 k, a_o[k], b_o[k], busy[k], done[k], vec_cnt[k]);
      end
    end
    $display("reset_mid after %0d cycles: outputs checked", wait_c);
    @(negedge clk) rst_n = 1'b1;
    test_sweep(0, "post_reset", -1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);

    test_sweep(0, "clean", -1);
    fa = int'($urandom_range(0, (1 << W) - 1));
    fb = int'($urandom_range(0, (1 << W) - 1));
    mask = RW'($urandom_range(1, (1 << RW) - 1));
    test_sweep(1, "single_fault", -1);
    test_restart();
    test_sweep(2, "b_all_ones", -1);
    seed = int'($urandom_range(0, 1000));
    mask = RW'($urandom_range(1, (1 << RW) - 1));
    test_sweep(3, "scatter", -1);
    test_sweep(0, "start_while_busy", int'($urandom_range(20, 1500)));
    fa = (1 << W) - 1;
    fb = (1 << W) - 1;
    test_sweep(1, "last_vector", -1);
    test_abort(100);
    test_abort(1);
    test_abort(int'($urandom_range(2, 1500)));
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
